// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS constants (opcodes, NOP, instruction field
//                positions), field helpers and the IF/ID stage state type.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [5:0]  OP_LW    = 6'h23;

    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Instruction field positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // IF/ID stage condition: RUN (normal), STALL (load-use hold), SQUASH (flushed)
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } ifid_state_t;

    function automatic logic [5:0] inst_op(input logic [31:0] inst);
        return inst[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [4:0] inst_rs(input logic [31:0] inst);
        return inst[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] inst_rt(input logic [31:0] inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detection between the load in
//                ID/EX and the instruction currently held in IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
    import mips_pkg::*;
(
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic [4:0]  i_ex_rt,
    input  logic [31:0] i_inst,
    output logic        o_hazard
);

    logic       w_rs_match;
    logic       w_rt_match;
    logic       w_rt_is_src;
    logic [5:0] w_op;

    // rt is only a source register for R-type, branches and stores
    always_comb begin
        w_op        = inst_op(i_inst);
        w_rs_match  = (i_ex_rt == inst_rs(i_inst));
        w_rt_match  = (i_ex_rt == inst_rt(i_inst));
        w_rt_is_src = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                      (w_op == OP_BNE)   || (w_op == OP_SW);
        o_hazard    = i_valid && i_mem_read && (i_ex_rt != 5'd0) &&
                      (w_rs_match || (w_rt_match && w_rt_is_src));
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : IF/ID pipeline register with load-use stall, branch flush
//                squash and saturating stall/flush event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      pc4_in,
    input  logic             flush,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    output logic [31:0]      inst_out,
    output logic [31:0]      pc4_out,
    output logic             valid_out,
    output logic             PCWrite,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    ifid_state_t      r_state;
    ifid_state_t      w_state_nxt;
    logic [31:0]      r_inst;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;
    logic             w_stall;

    hazard_detect u_hazard_detect (
        .i_valid    (r_valid),
        .i_mem_read (idex_mem_read),
        .i_ex_rt    (idex_rt),
        .i_inst     (r_inst),
        .o_hazard   (w_hazard)
    );

    // Flush overrides the hazard; only an unflushed hazard freezes the stage
    always_comb begin
        w_stall     = w_hazard && !flush;
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = SQUASH;
        end else if (w_hazard) begin
            w_state_nxt = STALL;
        end else begin
            w_state_nxt = RUN;
        end
    end

    // Control outputs; bubble is forced while reset holds the stage empty
    always_comb begin
        PCWrite = !w_stall;
        bubble  = !reset || flush || w_hazard;
    end

    // State flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pipeline register: squash on flush, hold on stall, load otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst  <= NOP;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_inst  <= NOP;
            r_pc4   <= pc4_in;
            r_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_inst  <= inst_in;
            r_pc4   <= pc4_in;
            r_valid <= 1'b1;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign inst_out  = r_inst;
    assign pc4_out   = r_pc4;
    assign valid_out = r_valid;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : if_id_stage
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage (default and 2-bit
//                counter instances) against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_in;
    logic [31:0] pc4_in;
    logic        flush;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;

    logic [31:0] inst_out, pc4_out, s_inst_out, s_pc4_out;
    logic        valid_out, PCWrite, bubble, s_valid_out, s_PCWrite, s_bubble;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [31:0] m_inst, m_pc4;
    logic        m_valid;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    if_id_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .inst_in(inst_in), .pc4_in(pc4_in),
        .flush(flush), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .inst_out(inst_out), .pc4_out(pc4_out), .valid_out(valid_out),
        .PCWrite(PCWrite), .bubble(bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .inst_in(inst_in), .pc4_in(pc4_in),
        .flush(flush), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .inst_out(s_inst_out), .pc4_out(s_pc4_out), .valid_out(s_valid_out),
        .PCWrite(s_PCWrite), .bubble(s_bubble),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load-use rule written directly from the field definitions
    function automatic bit model_hazard();
        int op, rs, rt;
        op = int'(m_inst >> 26) & 63;
        rs = int'(m_inst >> 21) & 31;
        rt = int'(m_inst >> 16) & 31;
        if (!m_valid || !idex_mem_read || idex_rt == 0) return 0;
        if (int'(idex_rt) == rs) return 1;
        return (int'(idex_rt) == rt) && (op == 0 || op == 4 || op == 5 || op == 43);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        m_inst = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    endtask

    // Compare every DUT output (both instances) against the model
    task automatic compare_all();
        bit hz;
        hz = model_hazard();
        chk("inst_out",  inst_out,  m_inst);
        chk("pc4_out",   pc4_out,   m_pc4);
        chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        chk("PCWrite",   {31'd0, PCWrite},   {31'd0, !(reset && !flush && hz)});
        chk("bubble",    {31'd0, bubble},    {31'd0, (!reset || flush || hz)});
        chk("stall_cnt", {16'd0, stall_cnt}, (m_stall > 65535) ? 32'd65535 : m_stall);
        chk("flush_cnt", {16'd0, flush_cnt}, (m_flush > 65535) ? 32'd65535 : m_flush);
        chk("sat_inst_out",  s_inst_out, m_inst);
        chk("sat_PCWrite",   {31'd0, s_PCWrite}, {31'd0, PCWrite});
        chk("sat_stall_cnt", {30'd0, s_stall_cnt}, (m_stall > 3) ? 32'd3 : m_stall);
        chk("sat_flush_cnt", {30'd0, s_flush_cnt}, (m_flush > 3) ? 32'd3 : m_flush);
    endtask

    // Inputs are set at the falling edge; check, clock, advance model
    task automatic tick();
        bit hz;
        #1 compare_all();
        hz = model_hazard();
        @(posedge clk);
        if (reset) begin
            if (flush) begin
                m_inst = 0; m_pc4 = pc4_in; m_valid = 0; m_flush = sat(m_flush, 1 << 20);
            end else if (hz) begin
                m_stall = sat(m_stall, 1 << 20);
            end else begin
                m_inst = inst_in; m_pc4 = pc4_in; m_valid = 1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [6];
        logic [31:0] r;
        ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h0F};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 5)];
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        // ---- reset ----
        reset = 0; inst_in = 32'h8C010004; pc4_in = 32'h4; flush = 0;
        idex_mem_read = 0; idex_rt = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_PCWrite", {31'd0, PCWrite}, 32'd1);
        chk("rst_bubble", {31'd0, bubble}, 32'd1);
        tick();
        reset = 1;
        tick();
        chk("first_inst", inst_out, 32'h8C010004);
        chk("first_valid", {31'd0, valid_out}, 32'd1);

        // ---- load-use ----
        inst_in = 32'h00221820; pc4_in = 32'h8;
        tick();
        inst_in = 32'h11111111; pc4_in = 32'hC; idex_mem_read = 1; idex_rt = 1;
        #1;
        chk("lu_PCWrite", {31'd0, PCWrite}, 32'd0);
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        tick();
        chk("lu_hold", inst_out, 32'h00221820);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        idex_mem_read = 0;
        #1 chk("lu_resume", {31'd0, PCWrite}, 32'd1);
        tick();

        // ---- no false hazard ----
        idex_mem_read = 1; idex_rt = 0;
        #1 chk("nf_rt0", {31'd0, bubble}, 32'd0);
        inst_in = 32'h8C220000; idex_mem_read = 0;
        tick();
        idex_mem_read = 1; idex_rt = 2;
        #1 chk("nf_lw_rt", {31'd0, PCWrite}, 32'd1);
        chk("nf_lw_bubble", {31'd0, bubble}, 32'd0);
        inst_in = 32'h00221820; idex_mem_read = 0;
        tick();

        // ---- flush + hazard ----
        flush = 1; idex_mem_read = 1; idex_rt = 1;
        #1 chk("fh_PCWrite", {31'd0, PCWrite}, 32'd1);
        tick();
        flush = 0;
        chk("fh_inst", inst_out, 32'h0);
        chk("fh_valid", {31'd0, valid_out}, 32'd0);
        chk("fh_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("fh_stall_cnt", {16'd0, stall_cnt}, 32'd1);

        // ---- saturation: 5 hazard cycles ----
        idex_mem_read = 0;
        tick();
        idex_mem_read = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_lit", {30'd0, s_stall_cnt}, 32'd3);
        chk("sat_wide_lit", {16'd0, stall_cnt}, 32'd6);

        // ---- reset mid-stall ----
        #2 reset = 0;
        model_reset();
        #1;
        chk("rms_inst", inst_out, 32'h0);
        chk("rms_valid", {31'd0, valid_out}, 32'd0);
        chk("rms_PCWrite", {31'd0, PCWrite}, 32'd1);
        @(negedge clk);
        tick();
        reset = 1;

        // ---- randomized ----
        for (int n = 0; n < 3000; n++) begin
            inst_in       = rand_inst();
            pc4_in        = $urandom;
            flush         = ($urandom_range(0, 99) < 12);
            idex_mem_read = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 3))
                0: idex_rt = m_inst[25:21];
                1: idex_rt = m_inst[20:16];
                2: idex_rt = 5'($urandom_range(0, 7));
                default: idex_rt = 5'd0;
            endcase
            if (!reset) begin
                reset = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                #2 reset = 0;
                model_reset();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_stage
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 One clock; reset is asynchronous and active-low. Ports are named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 inst_in  input  32  instruction from the fetch stage.
REQ-006 pc4_in  input  32  next-PC value from the fetch stage.
REQ-007 flush  input  1  branch or jump redirect taken in EX; squashes the fetched instruction.
REQ-008 idex_mem_read  input  1  the instruction in ID/EX is a load.
REQ-009 idex_rt  input  5  destination register of the load in ID/EX.
REQ-010 inst_out  output  32  registered instruction presented to decode.
REQ-011 pc4_out  output  32  registered next-PC presented to decode.
REQ-012 valid_out  output  1  inst_out is a real, unsquashed instruction.
REQ-013 PCWrite  output  1  drives the fetch PC-register enable.
REQ-014 bubble  output  1  tells the ID/EX control mux to insert zero controls this cycle.
REQ-015 stall_cnt  output  CNT_W  saturating count of load-use stall cycles.
REQ-016 flush_cnt  output  CNT_W  saturating count of flush cycles.

Function
REQ-017 Hazard (combinational):
  - Condition: valid_out & idex_mem_read & idex_rt!=0.
  - AND either idex_rt==inst_out[25:21], or (idex_rt==inst_out[20:16] and opcode inst_out[31:26] is one of 0x00, 0x04, 0x05, 0x2B).
REQ-018 Priority each cycle: flush > hazard > normal.
REQ-019 Normal (no flush, no hazard):
  - PCWrite=1, bubble=0.
  - At the clock edge, inst_out<=inst_in, pc4_out<=pc4_in, valid_out<=1.
REQ-020 Hazard without flush:
  - PCWrite=0, bubble=1.
  - inst_out, pc4_out and valid_out hold their values.
  - stall_cnt increments.
REQ-021 Flush, with or without a hazard:
  - PCWrite=1, bubble=1.
  - At the clock edge, inst_out<=NOP (32'h0000_0000), pc4_out<=pc4_in, valid_out<=0.
  - flush_cnt increments.
REQ-022 After a flush, a NOP with valid_out=0 never raises a hazard, so fetch resumes the following cycle.
REQ-023 Latency: inst_in appears on inst_out exactly 1 cycle after an unstalled edge.
REQ-024 A load-use stall lasts exactly 1 cycle per load, because ID/EX receives a bubble and idex_mem_read drops.
REQ-025 Back-to-back hazards, caused by a held idex_mem_read, stall for every cycle the condition holds; no cycle limit applies.
REQ-026 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-027 Block state machine: RUN, STALL, SQUASH.
  - STALL: registered flag set on a hazard edge.
  - SQUASH: registered flag set on a flush edge.
  - The state is exposed only through valid_out and the counters.
  - Transitions follow REQ-019 to REQ-021 evaluated every cycle.

Reset
REQ-028 While reset=0, independent of clk:
  - inst_out=0, pc4_out=0, valid_out=0.
  - stall_cnt=0, flush_cnt=0, state=RUN.
REQ-029 During reset, PCWrite=1 and bubble=1.
REQ-030 Reset asserted mid-stall or mid-flush discards the held instruction. The first edge after deassertion behaves as normal.

Structure
REQ-031 Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B, OP_LW=6'h23;
  - NOP=32'h0;
  - field-slice constants for rs, rt and opcode.
REQ-032 One sub-module, hazard_detect, is combinational and implements REQ-017. It is instantiated once. Registers, priority logic and counters stay in if_id_stage.

Verification
REQ-033 Reset: hold reset=0 with inst_in=32'h8C010004 -> all outputs match REQ-028/029. On release, one edge -> inst_out=32'h8C010004, valid_out=1.
REQ-034 Load-use: inst_out=32'h00221820 (add $3,$1,$2), idex_mem_read=1, idex_rt=1 -> PCWrite=0, bubble=1, inst_out held one cycle, stall_cnt=1. With idex_mem_read=0 next cycle -> normal.
REQ-035 No false hazard: idex_rt=0, or idex_rt=2 with inst_out=32'h8C220000 (lw, rt is a destination) -> PCWrite=1, bubble=0.
REQ-036 Flush plus hazard in the same cycle -> PCWrite=1, next inst_out=0, valid_out=0, flush_cnt=1, stall_cnt unchanged.
REQ-037 Saturation: set CNT_W=2, apply 5 hazard cycles -> stall_cnt=3.
REQ-038 Reset mid-stall: assert reset during a hazard cycle -> inst_out=0 immediately, valid_out=0, PCWrite=1.
